// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences one multiply or divide on the shared Mult/Div resource. It pulses
// the chosen unit's start line and waits for that unit's stop strobe, with a
// watchdog on the wait. It then writes HI/LO and reports completion,
// divide-by-zero or timeout.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   req, is_div, operand_b request from the main control FSM (sampled in IDLE)
//   StopMult, DivStop     completion strobes from Mult / Div
//   StartMult, StartDiv   one-cycle start pulses
//   DivMultMux            HI/LO source select (0 = Div, 1 = Mult)
//   RegHighW, RegLowW     HI/LO write enables
//   busy                  high outside IDLE; the control FSM stalls on it
//   done, div_zero, timeout  one-cycle completion status pulses
module muldiv_sequencer #(
    parameter int MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        is_div,
    input  logic [31:0] operand_b,
    input  logic        StopMult,
    input  logic        DivStop,
    output logic        StartMult,
    output logic        StartDiv,
    output logic        DivMultMux,
    output logic        RegHighW,
    output logic        RegLowW,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4,
        EXC   = 3'd5,
        TOUT  = 3'd6
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_CYCLES - 1);

    state_t     state, stateNext;
    logic       opDiv;
    logic [7:0] waitCnt;
    logic       selStop;

    // Only the unit that was started may end the wait.
    assign selStop = opDiv ? DivStop : StopMult;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            opDiv      <= 1'b0;
            DivMultMux <= 1'b0;
            waitCnt    <= 8'd0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (req) begin
                    opDiv      <= is_div;
                    DivMultMux <= ~is_div;
                end
                START: waitCnt <= 8'd0;
                // Counting past the exit cycle is harmless: START clears it.
                WAIT:  waitCnt <= waitCnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        StartMult = 1'b0;
        StartDiv  = 1'b0;
        RegHighW  = 1'b0;
        RegLowW   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        div_zero  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req)
                    stateNext = (is_div && operand_b == 32'd0) ? EXC : START;
            end
            START: begin
                StartDiv  = opDiv;
                StartMult = ~opDiv;
                stateNext = WAIT;
            end
            WAIT: begin
                // The strobe takes priority over the watchdog in the last cycle.
                if (selStop)                    stateNext = WRITE;
                else if (waitCnt == LAST_WAIT)  stateNext = TOUT;
            end
            WRITE: begin
                RegHighW  = 1'b1;
                RegLowW   = 1'b1;
                stateNext = FIN;
            end
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            EXC: begin
                done      = 1'b1;
                div_zero  = 1'b1;
                stateNext = IDLE;
            end
            TOUT: begin
                done      = 1'b1;
                timeout   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multicycle datapath's multiply/divide resource (the Mult and Div units, the DivMultHigh/DivMultLow muxes, and the High/Low registers). The main control FSM hands it one mult or div request. The block then:
- pulses the chosen unit's start line;
- waits for its completion strobe, guarded by a watchdog;
- steers and writes HI/LO;
- reports done, a divide-by-zero exception or a timeout.

The main control FSM stalls on `busy`.

## Interface
Parameters:
- `MAX_CYCLES`, default 40: watchdog limit. This is the number of WAIT cycles allowed before a timeout is declared. Legal range is 2..255.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  operation request from control unit; sampled only in IDLE.
- `is_div`  in  1  sampled with `req`: 1 = div, 0 = mult.
- `operand_b`  in  32  divisor (register B output); sampled with `req`.
- `StopMult`  in  1  Mult completion strobe.
- `DivStop`  in  1  Div completion strobe.
- `StartMult`  out  1  one-cycle start pulse to Mult.
- `StartDiv`  out  1  one-cycle start pulse to Div.
- `DivMultMux`  out  1  HI/LO source select: 0 = Div, 1 = Mult.
- `RegHighW`  out  1  High register write enable.
- `RegLowW`  out  1  Low register write enable.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse (normal, exception or timeout).
- `div_zero`  out  1  one-cycle pulse with `done` when the divisor was 0.
- `timeout`  out  1  one-cycle pulse with `done` when the watchdog expired.

## Operation
- States: IDLE, START, WAIT, WRITE, FIN, EXC, TOUT. Encoding is free.

IDLE:
- On `req`=1, latch `is_div` into `op_div` and drive `DivMultMux <= ~is_div`.
- If `is_div`=1 and `operand_b`=0, go to EXC. Otherwise go to START.
- `req`=0: stay in IDLE.

START:
- Assert `StartDiv` if `op_div`=1, else `StartMult`, for exactly this cycle.
- Clear the 8-bit `wait_cnt` to 0.
- Go to WAIT.

WAIT:
- Only the selected unit's stop strobe counts (`DivStop` if `op_div`=1, else `StopMult`). A strobe from the other unit is ignored.
- Selected strobe = 1: go to WRITE.
- Selected strobe = 0 and `wait_cnt` = `MAX_CYCLES`-1: go to TOUT.
- Otherwise increment `wait_cnt` and stay in WAIT.
- If the strobe arrives in the cycle the count reaches its limit, the strobe wins and the next state is WRITE.

WRITE:
- `RegHighW`=`RegLowW`=1 for this one cycle.
- `DivMultMux` is unchanged.
- Go to FIN.

FIN:
- `done`=1, then go to IDLE.

EXC:
- `done`=1 and `div_zero`=1.
- No start pulse is issued and HI/LO are not written.
- Go to IDLE.

TOUT:
- `done`=1 and `timeout`=1.
- HI/LO are not written.
- Go to IDLE.

Other rules:
- `req` outside IDLE is ignored (it is not queued).
- Stop strobes outside WAIT are ignored.
- `DivMultMux` changes only on an accepted `req`. Between operations it holds its last value.
- All outputs are registered or decoded purely from state. No input-to-output combinational path exists.

## Timing
- Reset (synchronous, overrides everything):
  - state = IDLE and `wait_cnt` = 0;
  - `DivMultMux`=0 and `op_div`=0;
  - every pulse output = 0 and `busy`=0.
- Reset asserted mid-operation:
  - the block returns to IDLE at the next edge;
  - no HI/LO write, `done` or start pulse is produced afterwards;
  - a stop strobe arriving after reset is ignored.
- Cycle numbering: `req` is accepted at edge 0.
  - Start pulse is high during cycle 1 (START).
  - The stop strobe is first seen in cycle 1+k of WAIT, with k ≥ 1.
  - HI/LO write in cycle 2+k; `done` in cycle 3+k. The block is back in IDLE in cycle 4+k and can accept a new `req` there.
- Divide-by-zero: `done`/`div_zero` in cycle 1, IDLE in cycle 2.
- Timeout: the strobe never arrives within WAIT cycles 0..`MAX_CYCLES`-1. TOUT occupies cycle 2+`MAX_CYCLES`.
- `busy` is high from cycle 1 through the cycle carrying `done`, inclusive.
- The control unit must hold its stall while `busy`=1. It must not re-assert `req` in the `done` cycle expecting acceptance.

## Test plan
- Mult, normal: `req`=1, `is_div`=0; `StopMult` at k=33.
  - `StartMult` pulses for 1 cycle and `StartDiv` never does.
  - `DivMultMux`=1; `RegHighW`/`RegLowW` high for exactly 1 cycle in cycle 35; `done` in cycle 36; `busy`=0 in cycle 37.
- Div, normal: `is_div`=1, `operand_b`=7, `DivStop` at k=32.
  - `DivMultMux`=0 from cycle 1; HI/LO written once; `done`=1, `div_zero`=0.
- Div by zero: `is_div`=1, `operand_b`=0.
  - `done`=`div_zero`=1 in cycle 1.
  - No start pulse and no HI/LO write; back in IDLE in cycle 2.
- Watchdog: `MAX_CYCLES`=40, mult with no `StopMult`.
  - `timeout`=`done`=1 in cycle 42 and no HI/LO write.
  - Repeat with `StopMult` in the final WAIT cycle (cycle 41): the operation must complete normally with a write.
- Crossed/stray strobes:
  - `DivStop` during a mult's WAIT: ignored.
  - `StopMult` in IDLE: ignored.
  - `req` pulsed during WAIT: ignored; exactly one `done` results.
- Reset mid-WAIT: assert `reset` for 1 cycle at k=10, then deliver `StopMult` at k=20.
  - `busy`=0 after the reset edge.
  - No write enable and no `done` ever follow.
  - `DivMultMux`=0.
